// File: rtl/mb_debug_axil_regs.sv
// ---------------------------------------------------------------------------
// mb_debug_axil_regs
//   AXI4-Lite slave holding four 32-bit read/write debug registers at byte
//   offsets 0x0, 0x4, 0x8 and 0xC. Single-beat transfers only, one write and
//   one read outstanding at a time; the write and read channels run
//   independently of each other.
//
// Ports
//   ACLK, ARESET                 clock (rising edge), synchronous active-high reset
//   S_AXI_AW*                    write address channel (AWPROT ignored)
//   S_AXI_W*                     write data channel with byte strobes
//   S_AXI_B*                     write response channel (BRESP always OKAY)
//   S_AXI_AR*                    read address channel (ARPROT ignored)
//   S_AXI_R*                     read data channel (RRESP always OKAY)
//   dbg_reg0..dbg_reg3           current register contents
//   dbg_wr_pulse                 bit n high for the one cycle register n is updated
// ---------------------------------------------------------------------------
module mb_debug_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   dbg_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   dbg_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   dbg_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   dbg_reg3,
    output logic [3:0]                      dbg_wr_pulse
);

    // state   | meaning
    // W_IDLE  | collecting AW and W (either order); AWREADY/WREADY high until captured
    // W_RESP  | register written, BVALID held until BREADY
    // R_IDLE  | ARREADY high, waiting for a read address
    // R_DATA  | RDATA/RVALID held until RREADY

    localparam int NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

    logic                          aw_got;
    logic                          w_got;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_hold;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_hold;
    logic [NUM_BYTES-1:0]          strb_hold;

    logic                          aw_hs;
    logic                          w_hs;
    logic                          ar_hs;
    logic                          do_write;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [NUM_BYTES-1:0]          wr_strb;
    logic [1:0]                    wr_sel;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata;

    // Protection bits and byte-offset address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

    // READY/VALID outputs come only from registered state, never from inputs.
    assign S_AXI_AWREADY = (w_state == W_IDLE) && !aw_got;
    assign S_AXI_WREADY  = (w_state == W_IDLE) && !w_got;
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = (r_state == R_IDLE);
    assign S_AXI_RVALID  = (r_state == R_DATA);
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RDATA   = rdata;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // The write lands on the edge where the second of AW/W is captured, so
    // the register, the pulse and BVALID all appear together after that edge.
    assign do_write = (w_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
    assign wr_addr  = aw_got ? aw_hold   : S_AXI_AWADDR;
    assign wr_data  = w_got  ? w_hold    : S_AXI_WDATA;
    assign wr_strb  = w_got  ? strb_hold : S_AXI_WSTRB;
    assign wr_sel   = wr_addr[3:2];

    assign dbg_reg0 = regs[0];
    assign dbg_reg1 = regs[1];
    assign dbg_reg2 = regs[2];
    assign dbg_reg3 = regs[3];

    // ---------------- write channel ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE:  if (do_write) w_state_next = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_got       <= 1'b0;
            w_got        <= 1'b0;
            aw_hold      <= '0;
            w_hold       <= '0;
            strb_hold    <= '0;
            dbg_wr_pulse <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            dbg_wr_pulse <= '0;
            if (aw_hs) begin
                aw_got  <= 1'b1;
                aw_hold <= S_AXI_AWADDR;
            end
            if (w_hs) begin
                w_got     <= 1'b1;
                w_hold    <= S_AXI_WDATA;
                strb_hold <= S_AXI_WSTRB;
            end
            if (do_write) begin
                dbg_wr_pulse[wr_sel] <= 1'b1;
                for (int k = 0; k < NUM_BYTES; k++) begin
                    if (wr_strb[k]) begin
                        regs[wr_sel][8*k +: 8] <= wr_data[8*k +: 8];
                    end
                end
            end
            if ((w_state == W_RESP) && S_AXI_BREADY) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
        end
    end

    // ---------------- read channel ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (S_AXI_ARVALID) r_state_next = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Sampling regs on the AR edge returns the pre-update value when a write
    // lands on that same edge.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rdata <= '0;
        end else if (ar_hs) begin
            rdata <= regs[S_AXI_ARADDR[3:2]];
        end
    end

endmodule

// File: tb/tb_mb_debug_axil_regs.sv
module tb_mb_debug_axil_regs;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] dbg_reg0;
    logic [31:0] dbg_reg1;
    logic [31:0] dbg_reg2;
    logic [31:0] dbg_reg3;
    logic [3:0]  dbg_wr_pulse;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    mb_debug_axil_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .dbg_reg0      (dbg_reg0),
        .dbg_reg1      (dbg_reg1),
        .dbg_reg2      (dbg_reg2),
        .dbg_reg3      (dbg_reg3),
        .dbg_wr_pulse  (dbg_wr_pulse)
    );

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // AW and W presented together; write response accepted immediately.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [3:0] exp_pulse,
                             input string tag);
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check({tag, " bvalid"},  32'(S_AXI_BVALID),  32'd1);
        check({tag, " bresp"},   32'(S_AXI_BRESP),   32'd0);
        check({tag, " pulse"},   32'(dbg_wr_pulse),  32'(exp_pulse));
        check({tag, " awready"}, 32'(S_AXI_AWREADY), 32'd0);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check({tag, " bvalid clr"}, 32'(S_AXI_BVALID),  32'd0);
        check({tag, " pulse clr"},  32'(dbg_wr_pulse),  32'd0);
        check({tag, " awready re"}, 32'(S_AXI_AWREADY), 32'd1);
        check({tag, " wready re"},  32'(S_AXI_WREADY),  32'd1);
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp_data, input string tag);
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        check({tag, " rvalid"},  32'(S_AXI_RVALID),  32'd1);
        check({tag, " rdata"},   S_AXI_RDATA,        exp_data);
        check({tag, " rresp"},   32'(S_AXI_RRESP),   32'd0);
        check({tag, " arready"}, 32'(S_AXI_ARREADY), 32'd0);
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        check({tag, " rvalid clr"}, 32'(S_AXI_RVALID),  32'd0);
        check({tag, " arready re"}, 32'(S_AXI_ARREADY), 32'd1);
    endtask

    initial begin
        ARESET        = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        tick();
        tick();
        ARESET = 1'b0;

        // Reset state
        check("rst awready", 32'(S_AXI_AWREADY), 32'd1);
        check("rst wready",  32'(S_AXI_WREADY),  32'd1);
        check("rst arready", 32'(S_AXI_ARREADY), 32'd1);
        check("rst bvalid",  32'(S_AXI_BVALID),  32'd0);
        check("rst rvalid",  32'(S_AXI_RVALID),  32'd0);
        check("rst rdata",   S_AXI_RDATA,        32'd0);
        check("rst pulse",   32'(dbg_wr_pulse),  32'd0);
        check("rst reg0",    dbg_reg0,           32'd0);
        check("rst reg3",    dbg_reg3,           32'd0);

        // Sequential writes then reads
        axi_write(4'h0, 32'h1, 4'hF, 4'b0001, "wr0");
        axi_write(4'h4, 32'h2, 4'hF, 4'b0010, "wr1");
        axi_write(4'h8, 32'h3, 4'hF, 4'b0100, "wr2");
        axi_write(4'hC, 32'h4, 4'hF, 4'b1000, "wr3");
        check("seq dbg_reg2", dbg_reg2, 32'h3);
        axi_read(4'h0, 32'h1, "rd0");
        axi_read(4'h4, 32'h2, "rd1");
        axi_read(4'h8, 32'h3, "rd2");
        axi_read(4'hC, 32'h4, "rd3");

        // Byte strobes
        axi_write(4'h4, 32'hAABBCCDD, 4'hF,    4'b0010, "strb full");
        axi_write(4'h4, 32'h11223344, 4'b0101, 4'b0010, "strb part");
        axi_read(4'h4, 32'hAA22CC44, "strb rd");

        // AW three cycles ahead of W
        S_AXI_AWADDR  = 4'h8;
        S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        check("awfirst awready", 32'(S_AXI_AWREADY), 32'd0);
        check("awfirst wready",  32'(S_AXI_WREADY),  32'd1);
        check("awfirst bvalid0", 32'(S_AXI_BVALID),  32'd0);
        tick();
        tick();
        check("awfirst bvalid1", 32'(S_AXI_BVALID),  32'd0);
        check("awfirst reg2 old", dbg_reg2, 32'h3);
        S_AXI_WDATA  = 32'hDEADBEEF;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        check("awfirst bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("awfirst pulse",  32'(dbg_wr_pulse), 32'b0100);
        check("awfirst reg2",   dbg_reg2,          32'hDEADBEEF);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("awfirst bdone", 32'(S_AXI_BVALID), 32'd0);
        axi_read(4'h8, 32'hDEADBEEF, "awfirst rd");

        // W three cycles ahead of AW
        S_AXI_WDATA  = 32'h0BADF00D;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        check("wfirst wready",  32'(S_AXI_WREADY),  32'd0);
        check("wfirst awready", 32'(S_AXI_AWREADY), 32'd1);
        tick();
        tick();
        check("wfirst bvalid0", 32'(S_AXI_BVALID), 32'd0);
        check("wfirst pulse0",  32'(dbg_wr_pulse), 32'd0);
        S_AXI_AWADDR  = 4'h8;
        S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        check("wfirst bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("wfirst pulse",  32'(dbg_wr_pulse), 32'b0100);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        axi_read(4'h8, 32'h0BADF00D, "wfirst rd");

        // B backpressure
        S_AXI_AWADDR  = 4'h0;
        S_AXI_WDATA   = 32'h55;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp bvalid",  32'(S_AXI_BVALID),  32'd1);
            check("bp awready", 32'(S_AXI_AWREADY), 32'd0);
            check("bp wready",  32'(S_AXI_WREADY),  32'd0);
            if (i > 0) check("bp pulse", 32'(dbg_wr_pulse), 32'd0);
            tick();
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("bp bdone", 32'(S_AXI_BVALID), 32'd0);

        // R backpressure
        S_AXI_ARADDR  = 4'h0;
        S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        S_AXI_ARADDR  = 4'h8;
        for (int i = 0; i < 4; i++) begin
            check("rbp rvalid",  32'(S_AXI_RVALID),  32'd1);
            check("rbp rdata",   S_AXI_RDATA,        32'h55);
            check("rbp arready", 32'(S_AXI_ARREADY), 32'd0);
            tick();
        end
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        check("rbp rdone",   32'(S_AXI_RVALID),  32'd0);
        check("rbp arready", 32'(S_AXI_ARREADY), 32'd1);

        // Same-cycle write/read collision on reg1
        axi_write(4'h4, 32'h5, 4'hF, 4'b0010, "coll pre");
        S_AXI_AWADDR  = 4'h4;
        S_AXI_WDATA   = 32'h9;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_ARADDR  = 4'h4;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        check("coll rvalid", 32'(S_AXI_RVALID), 32'd1);
        check("coll rdata",  S_AXI_RDATA,       32'h5);
        check("coll bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("coll reg1",   dbg_reg1,          32'h9);
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        check("coll bdone", 32'(S_AXI_BVALID), 32'd0);
        check("coll rdone", 32'(S_AXI_RVALID), 32'd0);
        axi_read(4'h4, 32'h9, "coll rd2");
        axi_read(4'h7, 32'h9, "unaligned rd");

        // Reset in the middle of a write
        S_AXI_AWADDR  = 4'hC;
        S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        check("mrst awready0", 32'(S_AXI_AWREADY), 32'd0);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        check("mrst awready1", 32'(S_AXI_AWREADY), 32'd1);
        check("mrst reg0", dbg_reg0, 32'd0);
        check("mrst reg1", dbg_reg1, 32'd0);
        check("mrst reg2", dbg_reg2, 32'd0);
        check("mrst reg3", dbg_reg3, 32'd0);
        S_AXI_WDATA  = 32'h77;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        check("mrst bvalid",  32'(S_AXI_BVALID),  32'd0);
        check("mrst pulse",   32'(dbg_wr_pulse),  32'd0);
        check("mrst reg3 w",  dbg_reg3,           32'd0);
        check("mrst awready", 32'(S_AXI_AWREADY), 32'd1);
        check("mrst wready",  32'(S_AXI_WREADY),  32'd0);
        tick();
        check("mrst bvalid2", 32'(S_AXI_BVALID), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
